// File: rtl/systolic_array_add_pkg.sv
// systolic_array_add_pkg: shared sizes, step schedule and operand/accumulator types
package systolic_array_add_pkg;
  localparam int WIDTH  = 8;
  localparam int N      = 4;
  localparam int STEPS  = 3 * N - 2;
  localparam int LOAD   = STEPS + 1;
  localparam int DONE   = STEPS + 2;
  localparam int STEP_W = $clog2(DONE + 1);
  localparam int IDX_W  = $clog2(N);
  typedef logic signed [WIDTH-1:0]   op_t;
  typedef logic signed [2*WIDTH-1:0] acc_t;
endpackage

// File: rtl/systolic_array_add_pe.sv
// systolic_pe: dual multiply-accumulate cell sharing one A operand, with int/Q1.7 scaling
module systolic_pe
  import systolic_array_add_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_int,
  input  op_t  i_a,
  input  op_t  i_b1,
  input  op_t  i_b2,
  output acc_t o_acc1,
  output acc_t o_acc2
);
  acc_t w_m1, w_m2, w_p1, w_p2;
  assign w_m1 = acc_t'(i_a) * acc_t'(i_b1);
  assign w_m2 = acc_t'(i_a) * acc_t'(i_b2);
  assign w_p1 = i_int ? w_m1 : (w_m1 >>> 7);
  assign w_p2 = i_int ? w_m2 : (w_m2 >>> 7);
  // accumulate scaled products on enabled steps; clear restarts the computation
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_acc1 <= '0;
      o_acc2 <= '0;
    end else if (i_clr) begin
      o_acc1 <= '0;
      o_acc2 <= '0;
    end else if (i_en) begin
      o_acc1 <= o_acc1 + w_p1;
      o_acc2 <= o_acc2 + w_p2;
    end
endmodule

// File: rtl/systolic_array_add.sv
// systolic_array_add: 4x4 output-stationary dual matrix multiply with optional bias add
module systolic_array_add
  import systolic_array_add_pkg::*;
(
  input  logic AddFlag,
  input  logic IntFlag,
  input  logic clk,
  input  logic _reset,
  input  logic _flush_acc,
  input  op_t  a00, a01, a02, a03, a10, a11, a12, a13,
  input  op_t  a20, a21, a22, a23, a30, a31, a32, a33,
  input  op_t  b1_00, b1_10, b1_20, b1_30, b1_01, b1_11, b1_21, b1_31,
  input  op_t  b1_02, b1_12, b1_22, b1_32, b1_03, b1_13, b1_23, b1_33,
  input  op_t  b2_00, b2_10, b2_20, b2_30, b2_01, b2_11, b2_21, b2_31,
  input  op_t  b2_02, b2_12, b2_22, b2_32, b2_03, b2_13, b2_23, b2_33,
  input  acc_t c1_00, c1_01, c1_02, c1_03, c1_10, c1_11, c1_12, c1_13,
  input  acc_t c1_20, c1_21, c1_22, c1_23, c1_30, c1_31, c1_32, c1_33,
  input  acc_t c2_00, c2_01, c2_02, c2_03, c2_10, c2_11, c2_12, c2_13,
  input  acc_t c2_20, c2_21, c2_22, c2_23, c2_30, c2_31, c2_32, c2_33,
  output acc_t result1_0, result1_1, result1_2, result1_3, result1_4, result1_5, result1_6, result1_7,
  output acc_t result1_8, result1_9, result1_10, result1_11, result1_12, result1_13, result1_14, result1_15,
  output acc_t result2_0, result2_1, result2_2, result2_3, result2_4, result2_5, result2_6, result2_7,
  output acc_t result2_8, result2_9, result2_10, result2_11, result2_12, result2_13, result2_14, result2_15
);
  op_t  w_a  [N][N];
  op_t  w_b1 [N][N];
  op_t  w_b2 [N][N];
  acc_t w_c1 [N*N];
  acc_t w_c2 [N*N];
  acc_t w_acc1 [N*N];
  acc_t w_acc2 [N*N];
  acc_t r_res1 [N*N];
  acc_t r_res2 [N*N];
  logic [STEP_W-1:0] r_step;
  assign w_a  = '{'{a00, a01, a02, a03}, '{a10, a11, a12, a13},
                  '{a20, a21, a22, a23}, '{a30, a31, a32, a33}};
  assign w_b1 = '{'{b1_00, b1_01, b1_02, b1_03}, '{b1_10, b1_11, b1_12, b1_13},
                  '{b1_20, b1_21, b1_22, b1_23}, '{b1_30, b1_31, b1_32, b1_33}};
  assign w_b2 = '{'{b2_00, b2_01, b2_02, b2_03}, '{b2_10, b2_11, b2_12, b2_13},
                  '{b2_20, b2_21, b2_22, b2_23}, '{b2_30, b2_31, b2_32, b2_33}};
  assign w_c1 = '{c1_00, c1_01, c1_02, c1_03, c1_10, c1_11, c1_12, c1_13,
                  c1_20, c1_21, c1_22, c1_23, c1_30, c1_31, c1_32, c1_33};
  assign w_c2 = '{c2_00, c2_01, c2_02, c2_03, c2_10, c2_11, c2_12, c2_13,
                  c2_20, c2_21, c2_22, c2_23, c2_30, c2_31, c2_32, c2_33};
  // each PE sees the wavefront index kk = t - i - j, which replaces explicit skew registers
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      localparam logic signed [STEP_W:0] OFS = (STEP_W+1)'(i + j);
      logic signed [STEP_W:0] w_kk;
      logic [IDX_W-1:0] w_idx;
      logic w_en;
      assign w_kk  = $signed({1'b0, r_step}) - OFS;
      assign w_idx = w_kk[IDX_W-1:0];
      assign w_en  = (r_step <= STEP_W'(STEPS)) && (w_kk[STEP_W:IDX_W] == '0);
      systolic_pe u_pe (
        .i_clk  (clk),
        .i_rst_n(_reset),
        .i_clr  (!_flush_acc),
        .i_en   (w_en),
        .i_int  (IntFlag),
        .i_a    (w_a[i][w_idx]),
        .i_b1   (w_b1[w_idx][j]),
        .i_b2   (w_b2[w_idx][j]),
        .o_acc1 (w_acc1[N*i+j]),
        .o_acc2 (w_acc2[N*i+j])
      );
    end
  end
  // step counter saturates after the load step; results latch once with the optional bias
  always_ff @(posedge clk or negedge _reset)
    if (!_reset) begin
      r_step <= '0;
      for (int k = 0; k < N*N; k++) begin
        r_res1[k] <= '0;
        r_res2[k] <= '0;
      end
    end else if (!_flush_acc) begin
      r_step <= '0;
      for (int k = 0; k < N*N; k++) begin
        r_res1[k] <= '0;
        r_res2[k] <= '0;
      end
    end else begin
      if (r_step != STEP_W'(DONE)) r_step <= r_step + STEP_W'(1);
      if (r_step == STEP_W'(LOAD))
        for (int k = 0; k < N*N; k++) begin
          r_res1[k] <= w_acc1[k] + (AddFlag ? w_c1[k] : '0);
          r_res2[k] <= w_acc2[k] + (AddFlag ? w_c2[k] : '0);
        end
    end
  assign {result1_0, result1_1, result1_2, result1_3} = {r_res1[0], r_res1[1], r_res1[2], r_res1[3]};
  assign {result1_4, result1_5, result1_6, result1_7} = {r_res1[4], r_res1[5], r_res1[6], r_res1[7]};
  assign {result1_8, result1_9, result1_10, result1_11} = {r_res1[8], r_res1[9], r_res1[10], r_res1[11]};
  assign {result1_12, result1_13, result1_14, result1_15} = {r_res1[12], r_res1[13], r_res1[14], r_res1[15]};
  assign {result2_0, result2_1, result2_2, result2_3} = {r_res2[0], r_res2[1], r_res2[2], r_res2[3]};
  assign {result2_4, result2_5, result2_6, result2_7} = {r_res2[4], r_res2[5], r_res2[6], r_res2[7]};
  assign {result2_8, result2_9, result2_10, result2_11} = {r_res2[8], r_res2[9], r_res2[10], r_res2[11]};
  assign {result2_12, result2_13, result2_14, result2_15} = {r_res2[12], r_res2[13], r_res2[14], r_res2[15]};
endmodule

// File: tb/tb_systolic_array_add.sv
// tb_systolic_array_add: scenario tasks checked against a plain matrix-product model
module tb_systolic_array_add;
  logic clk = 0, _reset = 0, _flush_acc = 1, AddFlag = 0, IntFlag = 1;
  logic signed [7:0]  a [4][4], b1 [4][4], b2 [4][4];
  logic signed [15:0] c1 [16], c2 [16], r1 [16], r2 [16];
  logic [15:0] e1 [16], e2 [16];
  int checks = 0, fails = 0;
  always #5 clk = ~clk;

  systolic_array_add dut (
    .AddFlag(AddFlag), .IntFlag(IntFlag), .clk(clk), ._reset(_reset), ._flush_acc(_flush_acc),
    .a00(a[0][0]), .a01(a[0][1]), .a02(a[0][2]), .a03(a[0][3]), .a10(a[1][0]), .a11(a[1][1]), .a12(a[1][2]), .a13(a[1][3]),
    .a20(a[2][0]), .a21(a[2][1]), .a22(a[2][2]), .a23(a[2][3]), .a30(a[3][0]), .a31(a[3][1]), .a32(a[3][2]), .a33(a[3][3]),
    .b1_00(b1[0][0]), .b1_10(b1[1][0]), .b1_20(b1[2][0]), .b1_30(b1[3][0]), .b1_01(b1[0][1]), .b1_11(b1[1][1]), .b1_21(b1[2][1]), .b1_31(b1[3][1]),
    .b1_02(b1[0][2]), .b1_12(b1[1][2]), .b1_22(b1[2][2]), .b1_32(b1[3][2]), .b1_03(b1[0][3]), .b1_13(b1[1][3]), .b1_23(b1[2][3]), .b1_33(b1[3][3]),
    .b2_00(b2[0][0]), .b2_10(b2[1][0]), .b2_20(b2[2][0]), .b2_30(b2[3][0]), .b2_01(b2[0][1]), .b2_11(b2[1][1]), .b2_21(b2[2][1]), .b2_31(b2[3][1]),
    .b2_02(b2[0][2]), .b2_12(b2[1][2]), .b2_22(b2[2][2]), .b2_32(b2[3][2]), .b2_03(b2[0][3]), .b2_13(b2[1][3]), .b2_23(b2[2][3]), .b2_33(b2[3][3]),
    .c1_00(c1[0]), .c1_01(c1[1]), .c1_02(c1[2]), .c1_03(c1[3]), .c1_10(c1[4]), .c1_11(c1[5]), .c1_12(c1[6]), .c1_13(c1[7]),
    .c1_20(c1[8]), .c1_21(c1[9]), .c1_22(c1[10]), .c1_23(c1[11]), .c1_30(c1[12]), .c1_31(c1[13]), .c1_32(c1[14]), .c1_33(c1[15]),
    .c2_00(c2[0]), .c2_01(c2[1]), .c2_02(c2[2]), .c2_03(c2[3]), .c2_10(c2[4]), .c2_11(c2[5]), .c2_12(c2[6]), .c2_13(c2[7]),
    .c2_20(c2[8]), .c2_21(c2[9]), .c2_22(c2[10]), .c2_23(c2[11]), .c2_30(c2[12]), .c2_31(c2[13]), .c2_32(c2[14]), .c2_33(c2[15]),
    .result1_0(r1[0]), .result1_1(r1[1]), .result1_2(r1[2]), .result1_3(r1[3]), .result1_4(r1[4]), .result1_5(r1[5]),
    .result1_6(r1[6]), .result1_7(r1[7]), .result1_8(r1[8]), .result1_9(r1[9]), .result1_10(r1[10]), .result1_11(r1[11]),
    .result1_12(r1[12]), .result1_13(r1[13]), .result1_14(r1[14]), .result1_15(r1[15]),
    .result2_0(r2[0]), .result2_1(r2[1]), .result2_2(r2[2]), .result2_3(r2[3]), .result2_4(r2[4]), .result2_5(r2[5]),
    .result2_6(r2[6]), .result2_7(r2[7]), .result2_8(r2[8]), .result2_9(r2[9]), .result2_10(r2[10]), .result2_11(r2[11]),
    .result2_12(r2[12]), .result2_13(r2[13]), .result2_14(r2[14]), .result2_15(r2[15])
  );

  // R = A*B (+C), product scaled by >>>7 in fractional mode, everything wrapped to 16 bits
  function automatic void model();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        int s1 = 0, s2 = 0;
        for (int k = 0; k < 4; k++) begin
          int p1 = int'(a[i][k]) * int'(b1[k][j]);
          int p2 = int'(a[i][k]) * int'(b2[k][j]);
          s1 += IntFlag ? p1 : (p1 >>> 7);
          s2 += IntFlag ? p2 : (p2 >>> 7);
        end
        if (AddFlag) begin
          s1 += int'(c1[4*i+j]);
          s2 += int'(c2[4*i+j]);
        end
        e1[4*i+j] = 16'(s1);
        e2[4*i+j] = 16'(s2);
      end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    _reset = 0;
    #2;
    _reset = 1;
  endtask

  task automatic fill(input logic signed [7:0] av, b1v, b2v, input logic signed [15:0] c1v, c2v);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a[i][j] = av; b1[i][j] = b1v; b2[i][j] = b2v;
        c1[4*i+j] = c1v; c2[4*i+j] = c2v;
      end
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a[i][j] = 8'($urandom); b1[i][j] = 8'($urandom); b2[i][j] = 8'($urandom);
        c1[4*i+j] = 16'($urandom); c2[4*i+j] = 16'($urandom);
      end
  endtask

  task automatic test_reset();
    randomize_inputs();
    _reset = 0;
    #3;
    for (int k = 0; k < 16; k++) begin
      checks += 2;
      if (r1[k] !== 16'h0) begin fails++; $display("FAIL reset r1[%0d] got=%h exp=0000", k, r1[k]); end
      if (r2[k] !== 16'h0) begin fails++; $display("FAIL reset r2[%0d] got=%h exp=0000", k, r2[k]); end
    end
    tick();
  endtask

  task automatic test_identity();
    randomize_inputs();
    IntFlag = 1; AddFlag = 1;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a[i][j] = (i == j) ? 8'sd1 : 8'sd0;
        b1[i][j] = 8'(4*i + j);
        c1[4*i+j] = 0;
      end
    model();
    start();
    for (int e = 1; e <= 11; e++) begin
      tick();
      for (int k = 0; k < 16; k++) begin
        checks++;
        if (r1[k] !== 16'h0) begin fails++; $display("FAIL identity_early edge%0d r1[%0d] got=%h exp=0000", e, k, r1[k]); end
      end
    end
    tick();
    for (int k = 0; k < 16; k++) begin
      checks += 2;
      if (r1[k] !== 16'(k)) begin fails++; $display("FAIL identity r1[%0d] got=%h exp=%h", k, r1[k], 16'(k)); end
      if (r2[k] !== e2[k]) begin fails++; $display("FAIL identity r2[%0d] got=%h exp=%h", k, r2[k], e2[k]); end
    end
  endtask

  task automatic test_const(input string nm, input logic intf, addf, input logic signed [7:0] av, b1v, b2v,
                            input logic signed [15:0] c1v, c2v, input logic [15:0] x1, x2);
    fill(av, b1v, b2v, c1v, c2v);
    IntFlag = intf; AddFlag = addf;
    start();
    repeat (12) tick();
    for (int k = 0; k < 16; k++) begin
      checks += 2;
      if (r1[k] !== x1) begin fails++; $display("FAIL %s r1[%0d] got=%h exp=%h", nm, k, r1[k], x1); end
      if (r2[k] !== x2) begin fails++; $display("FAIL %s r2[%0d] got=%h exp=%h", nm, k, r2[k], x2); end
    end
  endtask

  task automatic test_flush();
    test_const("bias", 1, 1, 1, 2, -3, 3, 5, 16'h000B, 16'hFFF9);
    _flush_acc = 0;
    tick();
    _flush_acc = 1;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (r1[k] !== 16'h0 || r2[k] !== 16'h0) begin fails++; $display("FAIL flush_clear [%0d] got=%h/%h exp=0000/0000", k, r1[k], r2[k]); end
    end
    repeat (3) tick();
    _flush_acc = 0;
    tick();
    _flush_acc = 1;
    for (int e = 1; e <= 11; e++) tick();
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (r1[k] !== 16'h0) begin fails++; $display("FAIL flush_early r1[%0d] got=%h exp=0000", k, r1[k]); end
    end
    tick();
    for (int k = 0; k < 16; k++) begin
      checks += 2;
      if (r1[k] !== 16'h000B) begin fails++; $display("FAIL flush_rerun r1[%0d] got=%h exp=000b", k, r1[k]); end
      if (r2[k] !== 16'hFFF9) begin fails++; $display("FAIL flush_rerun r2[%0d] got=%h exp=fff9", k, r2[k]); end
    end
  endtask

  task automatic test_reset_mid();
    test_const("bias2", 1, 1, 1, 2, -3, 3, 5, 16'h000B, 16'hFFF9);
    _reset = 0;
    #1;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (r1[k] !== 16'h0 || r2[k] !== 16'h0) begin fails++; $display("FAIL reset_async [%0d] got=%h/%h exp=0000/0000", k, r1[k], r2[k]); end
    end
    _reset = 1;
    repeat (5) tick();
    _reset = 0;
    #1;
    _reset = 1;
    for (int e = 1; e <= 11; e++) tick();
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (r1[k] !== 16'h0) begin fails++; $display("FAIL reset_mid_early r1[%0d] got=%h exp=0000", k, r1[k]); end
    end
    tick();
    for (int k = 0; k < 16; k++) begin
      checks += 2;
      if (r1[k] !== 16'h000B) begin fails++; $display("FAIL reset_mid r1[%0d] got=%h exp=000b", k, r1[k]); end
      if (r2[k] !== 16'hFFF9) begin fails++; $display("FAIL reset_mid r2[%0d] got=%h exp=fff9", k, r2[k]); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      randomize_inputs();
      IntFlag = 1'($urandom); AddFlag = 1'($urandom);
      model();
      start();
      repeat (12) tick();
      for (int k = 0; k < 16; k++) begin
        checks += 2;
        if (r1[k] !== e1[k]) begin fails++; $display("FAIL random%0d r1[%0d] got=%h exp=%h", n, k, r1[k], e1[k]); end
        if (r2[k] !== e2[k]) begin fails++; $display("FAIL random%0d r2[%0d] got=%h exp=%h", n, k, r2[k], e2[k]); end
      end
    end
  endtask

  task automatic test_hold();
    randomize_inputs();
    IntFlag = 0; AddFlag = 1;
    model();
    start();
    repeat (12) tick();
    randomize_inputs();
    IntFlag = 1; AddFlag = 0;
    repeat (6) tick();
    for (int k = 0; k < 16; k++) begin
      checks += 2;
      if (r1[k] !== e1[k]) begin fails++; $display("FAIL hold r1[%0d] got=%h exp=%h", k, r1[k], e1[k]); end
      if (r2[k] !== e2[k]) begin fails++; $display("FAIL hold r2[%0d] got=%h exp=%h", k, r2[k], e2[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_const("bias", 1, 1, 1, 2, -3, 3, 5, 16'h000B, 16'hFFF9);
    test_const("frac", 0, 0, 8'sh40, 4, 4, 100, 100, 16'h0008, 16'h0008);
    test_const("wrap", 1, 0, 127, 127, -128, 0, 0, 16'hFC04, 16'h0200);
    test_flush();
    test_reset_mid();
    test_random();
    test_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
